// File: rtl/video_frame_reader.sv
// Display-side frame buffer reader: requests a frame at each vsync rise and streams one pixel
// per active-video cycle, aligned with a one-cycle-delayed copy of the video timing.
module video_frame_reader #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned ADDR_BITS = 24,
  parameter int unsigned FRAME_LEN = 786432
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vs_in,
  input  logic                 hs_in,
  input  logic                 de_in,
  input  logic [1:0]           wr_index,
  output logic                 read_req,
  input  logic                 read_req_ack,
  output logic [1:0]           read_addr_index,
  output logic [ADDR_BITS-1:0] read_len,
  output logic                 read_en,
  input  logic [DATA_BITS-1:0] read_data,
  output logic                 vs_out,
  output logic                 hs_out,
  output logic                 de_out,
  output logic [DATA_BITS-1:0] rgb_out,
  output logic                 underrun
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReq    = 2'd1;
  localparam logic [1:0] StActive = 2'd2;

  localparam logic [ADDR_BITS-1:0] FrameLen = ADDR_BITS'(FRAME_LEN);

  logic [1:0]           state_q, state_d;
  logic [1:0]           wr_idx_meta_q, wr_idx_s_q;
  logic [ADDR_BITS-1:0] pix_cnt_q, pix_cnt_d;
  logic                 underrun_d;
  logic                 read_en_q;
  logic                 frame_start;
  logic                 start_accept;
  logic                 is_active;

  assign read_len     = FrameLen;
  // vs_out doubles as the delayed vsync used for edge detection.
  assign frame_start  = vs_in & ~vs_out;
  // A frame start during an outstanding request is ignored entirely.
  assign start_accept = frame_start & (state_q != StReq);
  assign is_active    = (state_q == StActive);
  assign read_en      = is_active & de_in & (pix_cnt_q < FrameLen);
  assign rgb_out      = read_en_q ? read_data : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (frame_start) state_d = StReq;
      StReq:    if (read_req_ack) state_d = StActive;
      StActive: if (frame_start) state_d = StReq;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (start_accept) begin
      pix_cnt_d = '0;
    end else if (read_en) begin
      pix_cnt_d = pix_cnt_q + ADDR_BITS'(1);
    end
  end

  always_comb begin
    underrun_d = underrun_q_sel();
  end

  function automatic logic underrun_q_sel();
    logic u;
    u = start_accept ? 1'b0 : underrun;
    // Pixels demanded with no frame open, or past the end of the frame.
    if (de_in && (!is_active || (pix_cnt_q == FrameLen))) u = 1'b1;
    return u;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      wr_idx_meta_q   <= 2'd0;
      wr_idx_s_q      <= 2'd0;
      pix_cnt_q       <= '0;
      underrun        <= 1'b0;
      read_en_q       <= 1'b0;
      read_req        <= 1'b0;
      read_addr_index <= 2'd0;
      vs_out          <= 1'b0;
      hs_out          <= 1'b0;
      de_out          <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_meta_q <= wr_index;
      wr_idx_s_q    <= wr_idx_meta_q;
      pix_cnt_q     <= pix_cnt_d;
      underrun      <= underrun_d;
      read_en_q     <= read_en;
      read_req      <= (state_d == StReq);
      if (start_accept) begin
        // Read the buffer completed just before the one being written.
        read_addr_index <= wr_idx_s_q - 2'd1;
      end
      vs_out <= vs_in;
      hs_out <= hs_in;
      de_out <= de_in;
    end
  end

endmodule

// File: tb/tb_video_frame_reader.sv
// Scoreboard bench for video_frame_reader with FRAME_LEN=16: stimulus queues expected pixels,
// a negedge monitor pops them whenever de_out is high.
module tb_video_frame_reader;

  localparam int unsigned DB = 16;
  localparam int unsigned AB = 24;
  localparam int unsigned FL = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vs_in, hs_in, de_in;
  logic [1:0]    wr_index;
  logic          read_req, read_req_ack;
  logic [1:0]    read_addr_index;
  logic [AB-1:0] read_len;
  logic          read_en;
  logic [DB-1:0] read_data;
  logic          vs_out, hs_out, de_out;
  logic [DB-1:0] rgb_out;
  logic          underrun;

  int tests = 0;
  int fails = 0;
  logic [DB-1:0] exp_q[$];

  int unsigned pop_cnt   = 0;
  int unsigned fifo_base = 0;
  int unsigned b;
  logic [2:0]  prev_in = 3'b000;
  logic        prev_rst = 1'b0;

  video_frame_reader #(
    .DATA_BITS(DB),
    .ADDR_BITS(AB),
    .FRAME_LEN(FL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vs_in          (vs_in),
    .hs_in          (hs_in),
    .de_in          (de_in),
    .wr_index       (wr_index),
    .read_req       (read_req),
    .read_req_ack   (read_req_ack),
    .read_addr_index(read_addr_index),
    .read_len       (read_len),
    .read_en        (read_en),
    .read_data      (read_data),
    .vs_out         (vs_out),
    .hs_out         (hs_out),
    .de_out         (de_out),
    .rgb_out        (rgb_out),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  // Read FIFO model: word n+1 (relative to fifo_base) appears the cycle after the n-th pop.
  always @(posedge clk) if (read_en) pop_cnt <= pop_cnt + 1;
  assign read_data = DB'(pop_cnt - fifo_base);

  always @(posedge clk) begin
    prev_in  <= {vs_in, hs_in, de_in};
    prev_rst <= rst_n;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_rst) check("timing_delay", 32'({vs_out, hs_out, de_out}), 32'(prev_in));
      check("req_en_excl", 32'(read_en & read_req), 32'd0);
      if (de_out) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rgb", 32'(rgb_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1;
    tick();
    tick();
    vs_in = 1'b0;
    tick();
  endtask

  task automatic ack_after(input int n);
    repeat (n) tick();
    read_req_ack = 1'b1;
    tick();
    read_req_ack = 1'b0;
  endtask

  // lines of 4 de cycles each; expected pixel p (1-based) or 0 past FL or when blanked.
  task automatic de_burst(input int lines, input bit blank);
    int p = 1;
    for (int l = 0; l < lines; l++) begin
      for (int k = 0; k < 4; k++) begin
        de_in = 1'b1;
        exp_q.push_back((blank || p > int'(FL)) ? DB'(0) : DB'(p));
        p++;
        tick();
      end
      de_in = 1'b0;
      hs_in = 1'b1;
      tick();
      hs_in = 1'b0;
      tick();
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
    wr_index = 2'd0; read_req_ack = 1'b0;
    repeat (3) tick();
    check("rst_read_req", 32'(read_req), 32'd0);
    check("rst_read_en", 32'(read_en), 32'd0);
    check("rst_rgb", 32'(rgb_out), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_index", 32'(read_addr_index), 32'd0);
    check("rst_read_len", 32'(read_len), 32'd16);
    check("rst_de_out", 32'(de_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // Nominal frame
    wr_index = 2'd2;
    repeat (3) tick();
    fifo_base = pop_cnt;
    vs_pulse();
    check("req_rise", 32'(read_req), 32'd1);
    check("idx_nominal", 32'(read_addr_index), 32'd1);
    ack_after(5);
    check("req_drop", 32'(read_req), 32'd0);
    b = pop_cnt;
    de_burst(4, 1'b0);
    check("en_nominal", pop_cnt - b, 32'd16);
    check("underrun_nominal", 32'(underrun), 32'd0);

    // Index wrap and mid-frame index stability
    wr_index = 2'd0;
    repeat (3) tick();
    fifo_base = pop_cnt;
    vs_pulse();
    check("idx_wrap", 32'(read_addr_index), 32'd3);
    ack_after(1);
    wr_index = 2'd3;
    repeat (4) tick();
    check("idx_stable", 32'(read_addr_index), 32'd3);
    b = pop_cnt;
    de_burst(4, 1'b0);
    check("en_wrap", pop_cnt - b, 32'd16);

    // Back-to-back: new frame with pix_cnt saturated
    fifo_base = pop_cnt;
    vs_pulse();
    check("req_b2b", 32'(read_req), 32'd1);
    check("idx_b2b", 32'(read_addr_index), 32'd2);
    ack_after(2);
    b = pop_cnt;
    de_burst(4, 1'b0);
    check("en_b2b", pop_cnt - b, 32'd16);
    check("underrun_b2b", 32'(underrun), 32'd0);

    // Overlong frame: 20 de cycles
    fifo_base = pop_cnt;
    vs_pulse();
    ack_after(1);
    b = pop_cnt;
    de_burst(5, 1'b0);
    check("en_overlong", pop_cnt - b, 32'd16);
    check("underrun_overlong", 32'(underrun), 32'd1);
    vs_pulse();
    check("underrun_clear", 32'(underrun), 32'd0);
    check("req_after_overlong", 32'(read_req), 32'd1);

    // Late ack: de while still in REQ
    b = pop_cnt;
    de_burst(1, 1'b1);
    check("en_late", pop_cnt - b, 32'd0);
    check("underrun_late", 32'(underrun), 32'd1);
    vs_pulse();
    check("req_hold", 32'(read_req), 32'd1);
    fifo_base = pop_cnt;
    ack_after(1);

    // Async reset mid-ACTIVE with de_in high
    check("underrun_pre_reset", 32'(underrun), 32'd1);
    de_in = 1'b1;
    #2;
    check("en_pre_reset", 32'(read_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_read_en", 32'(read_en), 32'd0);
    check("reset_read_req", 32'(read_req), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    check("reset_rgb", 32'(rgb_out), 32'd0);
    de_in = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("req_idle_after_reset", 32'(read_req), 32'd0);
    vs_pulse();
    check("req_after_reset", 32'(read_req), 32'd1);

    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
